// File: rtl/bus_burst_reader_if.sv
// Signal bundle for the burst reader: the custom-instruction port and the
// bus-master port. The master modport is the reader's view of these signals.
// The slave modport is the view of whoever drives the CI and answers the bus.
interface bus_burst_reader_if;
  // custom-instruction port
  logic        ci_start;
  logic        ci_cke;
  logic [7:0]  ci_n;
  logic [31:0] ci_value_a;
  logic [31:0] ci_value_b;
  logic [31:0] ci_result;
  logic        ci_done;
  // bus-master port
  logic        request_bus;
  logic        bus_grant;
  logic        begin_transaction_out;
  logic [31:0] address_data_out;
  logic        read_not_write_out;
  logic [3:0]  byte_enables_out;
  logic [7:0]  burst_size_out;
  logic        end_transaction_out;
  logic [31:0] address_data_in;
  logic        data_valid_in;
  logic        end_transaction_in;
  logic        bus_error_in;

  modport master (
    input  ci_start, ci_cke, ci_n, ci_value_a, ci_value_b,
    output ci_result, ci_done,
    output request_bus, begin_transaction_out, address_data_out, read_not_write_out,
           byte_enables_out, burst_size_out, end_transaction_out,
    input  bus_grant, address_data_in, data_valid_in, end_transaction_in, bus_error_in
  );

  modport slave (
    output ci_start, ci_cke, ci_n, ci_value_a, ci_value_b,
    input  ci_result, ci_done,
    input  request_bus, begin_transaction_out, address_data_out, read_not_write_out,
           byte_enables_out, burst_size_out, end_transaction_out,
    output bus_grant, address_data_in, data_valid_in, end_transaction_in, bus_error_in
  );
endinterface

// File: rtl/bus_burst_reader.sv
// DMA burst reader: pulls a block of 32-bit words from memory with burst reads
// into a local 512-word buffer. Software configures, starts, polls and drains it
// through custom instructions.
module bus_burst_reader #(
  parameter logic [7:0]  CUSTOM_INSTRUCTION_ID = 8'd0,
  parameter int unsigned MAX_BURST_SIZE        = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bus_burst_reader_if.master bus
);
  localparam logic [9:0] MAX_BURST = 10'(MAX_BURST_SIZE);
  localparam logic [9:0] MAX_COUNT = 10'd512;

  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_INIT, S_WAIT, S_DONE, S_ERR
  } state_e;

  state_e      state_q;
  logic [31:0] base_q;
  logic [31:0] addr_q;
  logic [9:0]  count_q;
  logic [9:0]  remaining_q;
  logic [9:0]  beats_left_q;
  logic [8:0]  buf_idx_q;
  logic        done_q;
  logic        error_q;
  logic        request_q;
  logic        begin_q;
  logic [31:0] addr_out_q;
  logic        rnw_q;
  logic [3:0]  be_q;
  logic [7:0]  burst_q;
  logic        end_out_q;
  logic        rd_pending_q;
  logic [31:0] rd_data_q;
  logic [31:0] buffer_mem [512];

  logic        ci_sel;
  logic [2:0]  ci_cmd;
  logic        busy;
  logic [9:0]  burst_n;
  logic        buf_we;
  logic        rd_req;
  logic [31:0] imm_result;
  logic        unused_ci_bits;

  assign ci_sel         = bus.ci_start && bus.ci_cke && (bus.ci_n == CUSTOM_INSTRUCTION_ID);
  assign ci_cmd         = bus.ci_value_a[2:0];
  assign unused_ci_bits = ^bus.ci_value_a[31:3];
  assign busy           = (state_q != S_IDLE);
  assign burst_n        = (remaining_q > MAX_BURST) ? MAX_BURST : remaining_q;
  // Words arriving after the announced burst length has been met are dropped.
  assign buf_we         = (state_q == S_WAIT) && !bus.bus_error_in && bus.data_valid_in
                          && (beats_left_q != 10'd0);
  // A buffer read issued while the previous one is still being answered is ignored.
  assign rd_req         = ci_sel && (ci_cmd == 3'd4) && !rd_pending_q;

  // Immediate-answer CI commands (everything except the buffer read).
  always_comb begin
    imm_result = 32'd0;
    case (ci_cmd)
      3'd3:    imm_result = {29'd0, error_q, done_q, busy};
      3'd5:    imm_result = base_q;
      3'd6:    imm_result = {22'd0, count_q};
      default: imm_result = 32'd0;
    endcase
  end

  // CI response: a pending buffer read takes the result bus; otherwise answer immediately.
  always_comb begin
    bus.ci_result = 32'd0;
    if (!rst_i) begin
      if (rd_pending_q)
        bus.ci_result = rd_data_q;
      else if (ci_sel)
        bus.ci_result = imm_result;
    end
  end

  assign bus.ci_done = !rst_i && (rd_pending_q || (ci_sel && (ci_cmd != 3'd4)));

  assign bus.request_bus           = request_q;
  assign bus.begin_transaction_out = begin_q;
  assign bus.address_data_out      = addr_out_q;
  assign bus.read_not_write_out    = rnw_q;
  assign bus.byte_enables_out      = be_q;
  assign bus.burst_size_out        = burst_q;
  assign bus.end_transaction_out   = end_out_q;

  // Buffer write port: one word per accepted data beat.
  always_ff @(posedge clk_i) begin
    if (buf_we)
      buffer_mem[buf_idx_q] <= bus.address_data_in;
  end

  // Buffer read port: registered read, answered on the following cycle.
  always_ff @(posedge clk_i) begin
    if (rd_req)
      rd_data_q <= buffer_mem[bus.ci_value_b[8:0]];
  end

  // Tracks an outstanding buffer read so its answer lands exactly one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      rd_pending_q <= 1'b0;
    else
      rd_pending_q <= rd_req;
  end

  // Configuration registers, transfer FSM and registered bus outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      base_q       <= 32'd0;
      addr_q       <= 32'd0;
      count_q      <= 10'd0;
      remaining_q  <= 10'd0;
      beats_left_q <= 10'd0;
      buf_idx_q    <= 9'd0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      request_q    <= 1'b0;
      begin_q      <= 1'b0;
      addr_out_q   <= 32'd0;
      rnw_q        <= 1'b0;
      be_q         <= 4'd0;
      burst_q      <= 8'd0;
      end_out_q    <= 1'b0;
    end else begin
      // Begin-phase outputs are one-cycle pulses and idle at zero.
      begin_q    <= 1'b0;
      addr_out_q <= 32'd0;
      rnw_q      <= 1'b0;
      be_q       <= 4'd0;
      burst_q    <= 8'd0;
      end_out_q  <= 1'b0;

      if (ci_sel && (ci_cmd == 3'd0))
        base_q <= {bus.ci_value_b[31:2], 2'b00};
      if (ci_sel && (ci_cmd == 3'd1))
        count_q <= (bus.ci_value_b[9:0] > MAX_COUNT) ? MAX_COUNT : bus.ci_value_b[9:0];

      case (state_q)
        S_IDLE: begin
          if (ci_sel && (ci_cmd == 3'd2)) begin
            // An empty transfer completes at once without touching the bus.
            done_q  <= (count_q == 10'd0);
            error_q <= 1'b0;
            if (count_q != 10'd0) begin
              addr_q      <= base_q;
              remaining_q <= count_q;
              buf_idx_q   <= 9'd0;
              request_q   <= 1'b1;
              state_q     <= S_REQUEST;
            end
          end
        end
        S_REQUEST: begin
          if (bus.bus_grant) begin
            request_q <= 1'b0;
            state_q   <= S_INIT;
          end
        end
        S_INIT: begin
          if (bus.bus_error_in) begin
            end_out_q <= 1'b1;
            error_q   <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_ERR;
          end else begin
            begin_q      <= 1'b1;
            addr_out_q   <= addr_q;
            rnw_q        <= 1'b1;
            be_q         <= 4'hF;
            burst_q      <= 8'(burst_n - 10'd1);
            remaining_q  <= remaining_q - burst_n;
            beats_left_q <= burst_n;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.bus_error_in) begin
            end_out_q <= 1'b1;
            error_q   <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_ERR;
          end else begin
            if (buf_we) begin
              buf_idx_q    <= buf_idx_q + 9'd1;
              addr_q       <= addr_q + 32'd4;
              beats_left_q <= beats_left_q - 10'd1;
            end
            if (bus.end_transaction_in) begin
              if (remaining_q != 10'd0) begin
                request_q <= 1'b1;
                state_q   <= S_REQUEST;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_burst_reader.sv
// Bench for the burst reader: a randomized memory responder on the bus side,
// software-like CI sequences on the other, and a burst/buffer reference model.
module tb_bus_burst_reader;
  localparam logic [7:0] ID   = 8'd0;
  localparam int         MAXB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_burst_reader_if bus_if ();

  bus_burst_reader #(
    .CUSTOM_INSTRUCTION_ID(ID),
    .MAX_BURST_SIZE(MAXB)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // responder configuration, set per transfer
  logic [31:0] xfer_base   = 32'd0;
  logic [31:0] data_off    = 32'd0;
  int          err_at      = -1;
  int          extra_words = 0;
  int          grant_delay = 0;
  int          resp_word   = 0;

  // observations
  logic [31:0] obs_addr[$];
  logic [7:0]  obs_size[$];
  int req_cycles = 0, end_cycles = 0, idle_viol = 0, attr_viol = 0, req_drop = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic ci_cmd(input logic [2:0] cmd, input logic [31:0] b,
                        output logic [31:0] res, output logic dn);
    @(negedge clk);
    bus_if.ci_start   = 1'b1;
    bus_if.ci_cke     = 1'b1;
    bus_if.ci_n       = ID;
    bus_if.ci_value_a = {29'd0, cmd};
    bus_if.ci_value_b = b;
    #1;
    res = bus_if.ci_result;
    dn  = bus_if.ci_done;
  endtask

  task automatic ci_idle();
    @(negedge clk);
    bus_if.ci_start = 1'b0;
    bus_if.ci_cke   = 1'b0;
  endtask

  task automatic read_buf(input int idx, output logic [31:0] res,
                          output logic dn_now, output logic dn_late);
    @(negedge clk);
    bus_if.ci_start   = 1'b1;
    bus_if.ci_cke     = 1'b1;
    bus_if.ci_n       = ID;
    bus_if.ci_value_a = 32'd4;
    bus_if.ci_value_b = 32'(idx);
    #1 dn_now = bus_if.ci_done;
    @(negedge clk);
    bus_if.ci_start = 1'b0;
    bus_if.ci_cke   = 1'b0;
    #1;
    dn_late = bus_if.ci_done;
    res     = bus_if.ci_result;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_size.delete();
    req_cycles = 0; end_cycles = 0; idle_viol = 0; attr_viol = 0; req_drop = 0;
    resp_word = 0;
  endtask

  // Run one whole transfer and compare against the reference model.
  task automatic run_xfer(input logic [31:0] base, input int count, input logic [31:0] doff,
                          input int err_word, input int extra, input int gdelay, input bit poke);
    logic [31:0] r, a, exp_base;
    logic        d, dn_now, dn_late;
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_size[$];
    int eff, rem, w, n, polls, valid, idx;
    bit err;

    xfer_base = base; data_off = doff; err_at = err_word;
    extra_words = extra; grant_delay = gdelay;
    clear_obs();
    eff = (count > 512) ? 512 : count;
    err = (err_word >= 0) && (err_word < eff);
    exp_base = base;

    ci_cmd(3'd0, base, r, d);
    ci_cmd(3'd1, 32'(count), r, d);
    ci_cmd(3'd2, 32'd0, r, d);
    check_eq("start_ack", d, 1'b1);
    if (poke) begin
      // Second start while busy with a new base must not disturb the transfer.
      exp_base = 32'h0000_9000;
      ci_cmd(3'd0, exp_base, r, d);
      ci_cmd(3'd2, 32'd0, r, d);
    end

    polls = 0;
    do begin
      ci_cmd(3'd3, 32'd0, r, d);
      polls++;
    end while (r[0] && polls < 5000);
    ci_idle();
    check_eq("xfer_finished", polls < 5000, 1'b1);
    if (eff == 0 && !poke) check_eq("zero_done_next_cycle", polls, 1);
    check_eq("status", r, err ? 32'd6 : 32'd2);
    repeat (6) @(negedge clk);

    // Reference: split into bursts of at most MAXB words; an error stops issuing further bursts.
    rem = eff; a = base; w = 0;
    while (rem > 0 && (!err || w <= err_word)) begin
      n = (rem < MAXB) ? rem : MAXB;
      exp_addr.push_back(a);
      exp_size.push_back(8'(n - 1));
      a   = a + 32'(4 * n);
      rem = rem - n;
      w   = w + n;
    end

    check_eq("burst_count", obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check_eq($sformatf("burst%0d_addr", i), obs_addr[i], exp_addr[i]);
      check_eq($sformatf("burst%0d_size", i), obs_size[i], exp_size[i]);
    end
    check_eq("req_cycles", req_cycles, exp_addr.size() * (gdelay + 1));
    check_eq("req_held", req_drop, 0);
    check_eq("end_out_cycles", end_cycles, err ? 1 : 0);
    check_eq("idle_bus_zero", idle_viol, 0);
    check_eq("begin_attrs", attr_viol, 0);

    ci_cmd(3'd5, 32'd0, r, d);
    check_eq("base_reg", r, exp_base);
    ci_cmd(3'd6, 32'd0, r, d);
    check_eq("count_reg", r, 32'(eff));
    ci_idle();

    valid = err ? err_word : eff;
    if (valid > 0) begin
      for (int k = 0; k < 3; k++) begin
        idx = (k == 0) ? 0 : (k == 1) ? valid - 1 : $urandom_range(0, valid - 1);
        read_buf(idx, r, dn_now, dn_late);
        check_eq($sformatf("buf[%0d]", idx), r, doff + 32'(idx));
        check_eq("buf_done_late", {dn_now, dn_late}, 2'b01);
      end
    end
    $display("xfer base=%08h count=%0d err_word=%0d bursts=%0d grant_delay=%0d status=%0h",
             base, count, err_word, obs_addr.size(), gdelay, err ? 6 : 2);
  endtask

  // Memory responder: grants after a delay, returns one burst of words with random gaps.
  initial begin : responder
    int rs, gcnt, k, nw, xk;
    logic [31:0] baddr;
    rs = 0; gcnt = 0; k = 0; nw = 0; xk = 0; baddr = 32'd0;
    bus_if.bus_grant = 1'b0; bus_if.data_valid_in = 1'b0; bus_if.end_transaction_in = 1'b0;
    bus_if.bus_error_in = 1'b0; bus_if.address_data_in = 32'd0;
    forever begin
      @(negedge clk);
      bus_if.bus_grant = 1'b0; bus_if.data_valid_in = 1'b0; bus_if.end_transaction_in = 1'b0;
      bus_if.bus_error_in = 1'b0; bus_if.address_data_in = 32'd0;
      if (rst) rs = 0;
      else begin
        case (rs)
          0: if (bus_if.request_bus) begin
               if (grant_delay == 0) begin bus_if.bus_grant = 1'b1; rs = 2; end
               else begin gcnt = grant_delay; rs = 1; end
             end
          1: begin
               if (!bus_if.request_bus) req_drop++;
               gcnt--;
               if (gcnt == 0) begin bus_if.bus_grant = 1'b1; rs = 2; end
             end
          2: if (bus_if.begin_transaction_out) begin
               baddr = bus_if.address_data_out;
               nw = int'(bus_if.burst_size_out) + 1;
               k = 0; xk = 0; rs = 3;
             end
          3: if ($urandom_range(0, 3) != 0) begin
               if (k < nw) begin
                 if (resp_word == err_at) begin
                   bus_if.bus_error_in = 1'b1;
                   rs = 0;
                 end else begin
                   bus_if.data_valid_in   = 1'b1;
                   bus_if.address_data_in = data_off + ((baddr + 32'(4 * k) - xfer_base) >> 2);
                   k++; resp_word++;
                 end
               end else if (xk < extra_words) begin
                 bus_if.data_valid_in   = 1'b1;
                 bus_if.address_data_in = 32'hDEAD_0000 + 32'(xk);
                 xk++;
               end else begin
                 bus_if.end_transaction_in = 1'b1;
                 rs = 0;
               end
             end
          default: rs = 0;
        endcase
      end
    end
  end

  // Bus monitor: records begin phases and counts request/end cycles and protocol slips.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_if.request_bus) req_cycles++;
        if (bus_if.end_transaction_out) end_cycles++;
        if (bus_if.begin_transaction_out) begin
          obs_addr.push_back(bus_if.address_data_out);
          obs_size.push_back(bus_if.burst_size_out);
          if (!bus_if.read_not_write_out || bus_if.byte_enables_out != 4'hF) attr_viol++;
        end else if (bus_if.address_data_out != 32'd0 || bus_if.burst_size_out != 8'd0 ||
                     bus_if.byte_enables_out != 4'd0 || bus_if.read_not_write_out) begin
          idle_viol++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin : main
    logic [31:0] r;
    logic        d, d2;
    int          cnt, ew, t;

    bus_if.ci_start = 1'b0; bus_if.ci_cke = 1'b0; bus_if.ci_n = 8'd0;
    bus_if.ci_value_a = 32'd0; bus_if.ci_value_b = 32'd0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ctrl_outs", {bus_if.request_bus, bus_if.begin_transaction_out,
             bus_if.read_not_write_out, bus_if.byte_enables_out, bus_if.burst_size_out,
             bus_if.end_transaction_out, bus_if.ci_done}, 32'd0);
    check_eq("rst_addr_out", bus_if.address_data_out, 32'd0);
    check_eq("rst_ci_result", bus_if.ci_result, 32'd0);
    rst = 1'b0;
    ci_cmd(3'd3, 32'd0, r, d); check_eq("rst_status", r, 32'd0); check_eq("status_done", d, 1'b1);
    ci_cmd(3'd5, 32'd0, r, d); check_eq("rst_base", r, 32'd0);
    ci_cmd(3'd6, 32'd0, r, d); check_eq("rst_count", r, 32'd0);
    ci_cmd(3'd7, 32'd0, r, d); check_eq("cmd7_result", r, 32'd0); check_eq("cmd7_done", d, 1'b1);
    ci_cmd(3'd0, 32'h1234_5677, r, d);
    ci_cmd(3'd5, 32'd0, r, d); check_eq("base_align", r, 32'h1234_5674);
    // deselected CI: wrong number, then clock enable low
    @(negedge clk);
    bus_if.ci_n = ID + 8'd1; #1;
    check_eq("wrong_id", {bus_if.ci_done, bus_if.ci_result}, 33'd0);
    bus_if.ci_n = ID; bus_if.ci_cke = 1'b0; #1;
    check_eq("cke_low", {bus_if.ci_done, bus_if.ci_result}, 33'd0);
    ci_idle();

    // single 4-word burst with fixed data, including buffer-read timing
    run_xfer(32'h1000, 4, 32'hA0, -1, 0, 0, 1'b0);
    @(negedge clk);
    bus_if.ci_start = 1'b1; bus_if.ci_cke = 1'b1; bus_if.ci_n = ID;
    bus_if.ci_value_a = 32'd4; bus_if.ci_value_b = 32'd0;
    #1 check_eq("rd_same_cycle_done", bus_if.ci_done, 1'b0);
    @(negedge clk);
    bus_if.ci_value_b = 32'd1;
    #1;
    check_eq("rd_b2b_first", bus_if.ci_result, 32'hA0);
    check_eq("rd_b2b_first_done", bus_if.ci_done, 1'b1);
    @(negedge clk);
    bus_if.ci_start = 1'b0; bus_if.ci_cke = 1'b0;
    #1 check_eq("rd_b2b_ignored", bus_if.ci_done, 1'b0);

    // three bursts 16/16/8 with extra trailing words that must be dropped
    run_xfer(32'h1000, 40, $urandom, -1, 1, $urandom_range(0, 3), 1'b0);
    // bus error on the third word
    run_xfer(32'h2000, 8, $urandom, 2, 0, 1, 1'b0);
    // empty transfer
    run_xfer(32'h3000, 0, $urandom, -1, 0, 0, 1'b0);
    // oversize count saturates to a full buffer
    run_xfer(32'h4000, 1000, $urandom, -1, 0, 0, 1'b0);
    // start while busy, long grant delay
    run_xfer(32'h5000, 20, $urandom, -1, 0, 20, 1'b1);
    // address wrap at 2^32
    run_xfer(32'hFFFF_FFC0, 20, $urandom, -1, 0, 1, 1'b0);
    // random transfers
    for (int it = 0; it < 5; it++) begin
      cnt = $urandom_range(1, 100);
      ew  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cnt - 1) : -1;
      run_xfer($urandom & 32'hFFFF_FFFC, cnt, $urandom, ew, $urandom_range(0, 2),
               $urandom_range(0, 4), 1'b0);
    end

    // reset in the middle of a transfer
    xfer_base = 32'h6000; data_off = $urandom; err_at = -1; extra_words = 0; grant_delay = 0;
    clear_obs();
    ci_cmd(3'd0, 32'h6000, r, d);
    ci_cmd(3'd1, 32'd40, r, d);
    ci_cmd(3'd2, 32'd0, r, d);
    ci_idle();
    t = 0;
    while (obs_addr.size() == 0 && t < 200) begin @(negedge clk); t++; end
    check_eq("reached_wait", t < 200, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_eq("wait_rst_ctrl_outs", {bus_if.request_bus, bus_if.begin_transaction_out,
             bus_if.read_not_write_out, bus_if.byte_enables_out, bus_if.burst_size_out,
             bus_if.end_transaction_out, bus_if.ci_done}, 32'd0);
    check_eq("wait_rst_addr_out", bus_if.address_data_out, 32'd0);
    check_eq("wait_rst_ci_result", bus_if.ci_result, 32'd0);
    rst = 1'b0;
    ci_cmd(3'd3, 32'd0, r, d); check_eq("wait_rst_status", r, 32'd0);
    ci_cmd(3'd5, 32'd0, r, d); check_eq("wait_rst_base", r, 32'd0);
    ci_cmd(3'd6, 32'd0, r, d); check_eq("wait_rst_count", r, 32'd0);
    ci_idle();
    repeat (10) @(negedge clk);
    check_eq("wait_rst_no_end_out", end_cycles, 0);
    ci_cmd(3'd3, 32'd0, r, d2); check_eq("wait_rst_stays_idle", r, 32'd0);
    ci_idle();
    run_xfer(32'h7000, 20, $urandom, -1, 0, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
